// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type constants and
// the registered receive-flag payload.
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef struct packed {
        logic data_valid;
        logic par_err;
        logic stp_err;
    } rx_flags_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver byte-sink interface: serial line and parity config in,
// parallel word and 1-cycle status pulses out.
interface uart_rx_core_if #(
    parameter int unsigned DATA_W = 8
);
    logic              RX_IN;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [DATA_W-1:0] P_DATA;
    logic              Data_Valid;
    logic              Par_Err;
    logic              Stp_Err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_core_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the cell centre.
module uart_rx_core_sampler
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_s,
    input  logic idle,
    output logic bit_val_c,
    output logic bit_rdy_c,
    output logic bit_end_c
);
    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned MID   = PRESCALE / 2;

    logic [CNT_W-1:0] edge_cnt;
    logic             smp_a;
    logic             smp_b;

    // While idle the start-detect cycle is count 0, so the next cycle is count 1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
        end else begin
            if (idle) begin
                edge_cnt <= rx_s ? '0 : CNT_W'(1);
            end else if (edge_cnt == CNT_W'(PRESCALE - 1)) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (edge_cnt == CNT_W'(MID - 1)) smp_a <= rx_s;
            if (edge_cnt == CNT_W'(MID))     smp_b <= rx_s;
        end
    end

    assign bit_val_c = maj3(smp_a, smp_b, rx_s);
    assign bit_rdy_c = !idle && (edge_cnt == CNT_W'(MID + 1));
    assign bit_end_c = !idle && (edge_cnt == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes RX_IN, frames start/data/parity/stop and
// presents the received word with one-cycle status pulses.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PRESCALE = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_core_if.slave  rx_if
);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              rx_meta;
    logic              rx_s;
    uart_state_e       state;
    uart_state_e       state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_en_q;
    logic              par_typ_q;
    logic              par_bad;
    logic              bit_val;
    logic              bit_rdy;
    logic              bit_end;
    logic              start_det;
    rx_flags_t         flags_q;
    rx_flags_t         flags_nxt;
    logic [DATA_W-1:0] p_data_q;
    logic [DATA_W-1:0] p_data_nxt;

    // Two-flop synchronizer, idle-high reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    uart_rx_core_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .CLK       (CLK),
        .RST       (RST),
        .rx_s      (rx_s),
        .idle      (state == ST_IDLE),
        .bit_val_c (bit_val),
        .bit_rdy_c (bit_rdy),
        .bit_end_c (bit_end)
    );

    assign start_det = (state == ST_IDLE) && !rx_s;

    // Frame datapath: config latch, bit counter, LSB-first shift, parity check
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad   <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_q  <= rx_if.PAR_EN;
                par_typ_q <= rx_if.PAR_TYP;
                bit_cnt   <= '0;
                par_bad   <= 1'b0;
            end
            if (state == ST_DATA && bit_rdy) begin
                shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
            end
            if (state == ST_DATA && bit_end) begin
                bit_cnt <= (bit_cnt == BIT_W'(DATA_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
            end
            if (state == ST_PARITY && bit_rdy) begin
                par_bad <= bit_val != ((^shift_reg) ^ par_typ_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_rdy && bit_val) state_nxt = ST_IDLE;
                else if (bit_end)       state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == BIT_W'(DATA_W - 1)) begin
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // Leave at the stop-bit centre so back-to-back frames are caught
                if (bit_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stop error outranks parity error; only a clean frame updates P_DATA
    always_comb begin
        flags_nxt  = '0;
        p_data_nxt = p_data_q;
        if (state == ST_STOP && bit_rdy) begin
            if (!bit_val) begin
                flags_nxt.stp_err = 1'b1;
            end else if (par_bad) begin
                flags_nxt.par_err = 1'b1;
            end else begin
                flags_nxt.data_valid = 1'b1;
                p_data_nxt           = shift_reg;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            flags_q  <= '0;
            p_data_q <= '0;
        end else begin
            flags_q  <= flags_nxt;
            p_data_q <= p_data_nxt;
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.Data_Valid = flags_q.data_valid;
    assign rx_if.Par_Err    = flags_q.par_err;
    assign rx_if.Stp_Err    = flags_q.stp_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame vectors with a flag/data
// scoreboard, plus reset-abort, glitch and back-to-back jitter sequences.
module tb_uart_rx_core;
    import uart_rx_core_pkg::*;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PRESCALE = 8;
    localparam int K_OK  = 0;
    localparam int K_PAR = 1;
    localparam int K_STP = 2;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_core_if #(.DATA_W(DATA_W)) rx_if ();

    uart_rx_core #(.DATA_W(DATA_W), .PRESCALE(PRESCALE)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rx_if.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       par_bit;
        logic       stop_bit;
        int         kind;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every flag pulse must match the oldest expected frame outcome
    always @(negedge CLK) begin
        if (!RST) begin
            exp_pdata = 8'h00;
        end else if (rx_if.Data_Valid || rx_if.Par_Err || rx_if.Stp_Err) begin
            exp_t e;
            int   act_kind;
            check("one_flag", 32'(int'(rx_if.Data_Valid) + int'(rx_if.Par_Err) + int'(rx_if.Stp_Err)), 32'd1);
            act_kind = rx_if.Data_Valid ? K_OK : (rx_if.Par_Err ? K_PAR : K_STP);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flag actual=%0d required=none", act_kind);
            end else begin
                e = sb_q.pop_front();
                check("flag_kind", 32'(act_kind), 32'(e.kind));
                if (e.kind == K_OK) exp_pdata = e.data;
                check("p_data", 32'(rx_if.P_DATA), 32'(exp_pdata));
            end
        end
    end

    task automatic send_bit(input logic b, input int len);
        rx_if.RX_IN = b;
        repeat (len) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_bit,
                              input logic stop_bit, input int jit_pos, input int jit);
        int idx = 0;
        send_bit(1'b0, PRESCALE + ((idx == jit_pos) ? jit : 0));
        idx++;
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i], PRESCALE + ((idx == jit_pos) ? jit : 0));
            idx++;
        end
        if (par_en) begin
            send_bit(par_bit, PRESCALE + ((idx == jit_pos) ? jit : 0));
            idx++;
        end
        send_bit(stop_bit, PRESCALE + ((idx == jit_pos) ? jit : 0));
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_p_data"}, 32'(rx_if.P_DATA), 32'd0);
        check({tag, "_dv"},     32'(rx_if.Data_Valid), 32'd0);
        check({tag, "_par"},    32'(rx_if.Par_Err), 32'd0);
        check({tag, "_stp"},    32'(rx_if.Stp_Err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, K_OK};
        vecs[1] = '{8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, K_PAR};
        vecs[2] = '{8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, K_OK};
        vecs[3] = '{8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, K_STP};
        vecs[4] = '{8'h5A, 1'b1, PAR_ODD,  1'b1, 1'b1, K_OK};
        vecs[5] = '{8'h01, 1'b1, PAR_ODD,  1'b1, 1'b1, K_PAR};
        vecs[6] = '{8'hC3, 1'b1, PAR_EVEN, 1'b1, 1'b0, K_STP};
        vecs[7] = '{8'hFF, 1'b1, PAR_EVEN, 1'b0, 1'b1, K_OK};

        RST           = 1'b0;
        rx_if.RX_IN   = 1'b1;
        rx_if.PAR_EN  = 1'b0;
        rx_if.PAR_TYP = PAR_EVEN;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        RST = 1'b1;
        send_bit(1'b1, 2 * PRESCALE);

        for (int v = 0; v < 8; v++) begin
            rx_if.PAR_EN  = vecs[v].par_en;
            rx_if.PAR_TYP = vecs[v].par_typ;
            sb_q.push_back('{vecs[v].kind, vecs[v].data});
            send_frame(vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop_bit, -1, 0);
            send_bit(1'b1, 2 * PRESCALE);
            drain("vec_drain", 200);
        end

        // Reset during the data bits aborts the frame silently
        rx_if.PAR_EN = 1'b0;
        send_bit(1'b0, PRESCALE);
        send_bit(1'b1, PRESCALE);
        send_bit(1'b0, PRESCALE);
        send_bit(1'b1, 3);
        RST         = 1'b0;
        rx_if.RX_IN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check_outputs_zero("mid_reset");
        RST = 1'b1;
        send_bit(1'b1, 2 * PRESCALE);
        sb_q.push_back('{K_OK, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 0);
        send_bit(1'b1, 2 * PRESCALE);
        drain("after_reset_drain", 200);

        // Short low glitch on the idle line must be rejected
        send_bit(1'b0, 2);
        send_bit(1'b1, 3 * PRESCALE);
        check("glitch_p_data", 32'(rx_if.P_DATA), 32'h5A);
        sb_q.push_back('{K_OK, 8'h96});
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, 0);
        send_bit(1'b1, 2 * PRESCALE);
        drain("after_glitch_drain", 200);

        // Back-to-back odd-parity frames with one stretched and one shortened cell
        rx_if.PAR_EN  = 1'b1;
        rx_if.PAR_TYP = PAR_ODD;
        sb_q.push_back('{K_OK, 8'h00});
        sb_q.push_back('{K_OK, 8'hFF});
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 3, 1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 5, -1);
        send_bit(1'b1, 2 * PRESCALE);
        drain("b2b_drain", 200);
        check("b2b_final_p_data", 32'(rx_if.P_DATA), 32'hFF);

        repeat (20) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
